stream_config_memory: RTL and testbench

- Parametrised configuration store for the SNN core; holds M words of N bits (synaptic weights / delay codes).
- Loaded over a valid/ready byte stream with an auto-incrementing write pointer, seekable via an address-load command.
- Provides a registered random-access readback port and a flat all-words bus feeding the neuron/delay datapath.
- Adds a sequential scrub (clear) engine, load-complete and overflow status, and selectable wrap/saturate pointer mode.

---
 rtl/snn_cfg_pkg.sv | 15 +
 rtl/cfg_mem_array.sv | 41 ++++
 rtl/stream_config_memory.sv | 128 ++++++++++++
 tb/tb_stream_config_memory.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cfg_pkg.sv
// Shared types and helpers for the SNN configuration store.
package snn_cfg_pkg;

  // Scrub engine state
  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } cfg_state_e;

  // Address width for an M-word store; never below one bit.
  function automatic int addr_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cfg_mem_array.sv
// M x N storage: one synchronous write port, clear-all, registered read, flat bus.
module cfg_mem_array #(
  parameter int M  = 162,
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [N-1:0]   wdata,
  input  logic [AW-1:0]  raddr,
  output logic [N-1:0]   rdata,
  output logic [M*N-1:0] all_data
);

  localparam logic [AW:0] M_EXT = M[AW:0];

  logic [M-1:0][N-1:0] mem;

  // One register per word; decoding the address per word keeps
  // out-of-range pointers from ever touching storage.
  for (genvar j = 0; j < M; j++) begin : g_word
    localparam logic [AW-1:0] IDX = j[AW-1:0];
    // Word j: cleared as a block, otherwise written when addressed
    always_ff @(posedge clk) begin
      if (clr)                        mem[j] <= '0;
      else if (we && (waddr == IDX))  mem[j] <= wdata;
    end
  end

  // Registered readback; reads the pre-write value, zero when out of range
  always_ff @(posedge clk) begin
    if (clr)                            rdata <= '0;
    else if ({1'b0, raddr} < M_EXT)     rdata <= mem[raddr];
    else                                rdata <= '0;
  end

  assign all_data = mem;

endmodule

// File: rtl/stream_config_memory.sv
// Stream-loaded configuration store with scrub engine and pointer status.
module stream_config_memory
  import snn_cfg_pkg::*;
#(
  parameter  int M    = 162,
  parameter  int N    = 8,
  parameter  int WRAP = 1,
  localparam int AW   = addr_width(M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           addr_load,
  input  logic [AW-1:0]  addr_in,
  input  logic           wr_valid,
  input  logic [N-1:0]   wr_data,
  output logic           wr_ready,
  input  logic [AW-1:0]  rd_addr,
  output logic [N-1:0]   rd_data,
  output logic [M*N-1:0] all_data_out,
  output logic [AW-1:0]  wr_ptr,
  output logic           load_done,
  output logic           overflow,
  output logic           busy
);

  localparam int          MM1   = M - 1;
  localparam logic [AW-1:0] LAST  = MM1[AW-1:0];
  localparam logic [AW:0] M_EXT = M[AW:0];
  localparam bit          SAT   = (WRAP == 0);

  cfg_state_e    state, state_nxt;
  logic [AW-1:0] scrub_ptr;
  logic          full;

  logic          addr_ok, addr_bad, accept, at_last;
  logic [AW-1:0] base_ptr, adv_ptr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [N-1:0]  mem_wdata;

  assign busy     = (state == SCRUB);
  assign wr_ready = (state == IDLE) && !full;

  // Handshake decode and pointer arithmetic; a valid address load
  // redirects the same-cycle write to addr_in.
  always_comb begin
    addr_ok  = addr_load && ({1'b0, addr_in} < M_EXT);
    addr_bad = addr_load && !addr_ok;
    accept   = wr_valid && wr_ready;
    base_ptr = addr_ok ? addr_in : wr_ptr;
    at_last  = (base_ptr == LAST);
    if (!at_last)  adv_ptr = base_ptr + 1'b1;
    else if (SAT)  adv_ptr = LAST;
    else           adv_ptr = '0;
  end

  // Single write port shared between the stream and the scrub engine
  always_comb begin
    mem_we    = accept;
    mem_waddr = base_ptr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = scrub_ptr;
      mem_wdata = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: scrub runs from word 0 through M-1 then returns
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear)              state_nxt = SCRUB;
      SCRUB:   if (scrub_ptr == LAST)  state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Pointer, scrub counter and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      scrub_ptr <= '0;
      wr_ptr    <= '0;
      full      <= 1'b0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE) begin
      if (clear) scrub_ptr <= '0;
      if (accept) begin
        wr_ptr <= adv_ptr;
        full   <= at_last && SAT;
        if (at_last) load_done <= 1'b1;
      end else if (addr_ok) begin
        wr_ptr <= addr_in;
        full   <= 1'b0;
      end
      if ((wr_valid && full) || addr_bad) overflow <= 1'b1;
    end else begin
      scrub_ptr <= scrub_ptr + 1'b1;
      if (scrub_ptr == LAST) begin
        scrub_ptr <= '0;
        wr_ptr    <= '0;
        full      <= 1'b0;
        load_done <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

  cfg_mem_array #(.M(M), .N(N), .AW(AW)) u_mem (
    .clk      (clk),
    .clr      (reset),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
    .raddr    (rd_addr),
    .rdata    (rd_data),
    .all_data (all_data_out)
  );

endmodule

// File: tb/tb_stream_config_memory.sv
// Bench: directed plan steps plus random traffic against a word-array model.
module tb_stream_config_memory;

  localparam int MA = 162;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: M=162, wrap mode
  logic           clear_a, addr_load_a, wr_valid_a, wr_ready_a;
  logic [7:0]     addr_in_a, rd_addr_a, wr_ptr_a, wr_data_a, rd_data_a;
  logic [MA*N-1:0] all_a;
  logic           load_done_a, overflow_a, busy_a;

  // instance B: M=4, saturate mode
  logic           clear_b, addr_load_b, wr_valid_b, wr_ready_b;
  logic [1:0]     addr_in_b, rd_addr_b, wr_ptr_b;
  logic [7:0]     wr_data_b, rd_data_b;
  logic [31:0]    all_b;
  logic           load_done_b, overflow_b, busy_b;

  stream_config_memory #(.M(MA), .N(N), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .addr_load(addr_load_a),
    .addr_in(addr_in_a), .wr_valid(wr_valid_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .all_data_out(all_a), .wr_ptr(wr_ptr_a), .load_done(load_done_a),
    .overflow(overflow_a), .busy(busy_a));

  stream_config_memory #(.M(4), .N(N), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .addr_load(addr_load_b),
    .addr_in(addr_in_b), .wr_valid(wr_valid_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .all_data_out(all_b), .wr_ptr(wr_ptr_b), .load_done(load_done_b),
    .overflow(overflow_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;

  // reference model of instance A
  int m_mem[MA];
  int m_ptr, m_sp, m_rd;
  bit m_ld, m_ov, m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flat(input string tag);
    logic [MA*N-1:0] exp;
    int bad;
    for (int j = 0; j < MA; j++) exp[j*N +: N] = m_mem[j][7:0];
    vectors++;
    assert (all_a === exp) else begin
      miscompares++;
      bad = 0;
      for (int j = MA - 1; j >= 0; j--) if (all_a[j*N +: N] !== exp[j*N +: N]) bad = j;
      $error("FAIL %s word %0d: observed %0h expected %0h", tag, bad,
             all_a[bad*N +: N], exp[bad*N +: N]);
    end
  endtask

  // One clock of the spec's rules at word level, using the inputs now applied
  task automatic model_step();
    if (reset) begin
      foreach (m_mem[j]) m_mem[j] = 0;
      m_ptr = 0; m_sp = 0; m_rd = 0; m_ld = 0; m_ov = 0; m_busy = 0;
      return;
    end
    m_rd = (int'(rd_addr_a) < MA) ? m_mem[rd_addr_a] : 0;
    if (m_busy) begin
      m_mem[m_sp] = 0;
      if (m_sp == MA - 1) begin
        m_busy = 0; m_ptr = 0; m_ld = 0; m_ov = 0;
      end else m_sp++;
    end else begin
      if (addr_load_a) begin
        if (int'(addr_in_a) < MA) m_ptr = addr_in_a;
        else                      m_ov = 1;
      end
      if (wr_valid_a) begin
        m_mem[m_ptr] = wr_data_a;
        if (m_ptr == MA - 1) m_ld = 1;
        m_ptr = (m_ptr + 1) % MA;
      end
      if (clear_a) begin
        m_busy = 1; m_sp = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("a_rd_data",   64'(rd_data_a),   64'(m_rd));
    chk("a_wr_ptr",    64'(wr_ptr_a),    64'(m_ptr));
    chk("a_load_done", 64'(load_done_a), 64'(m_ld));
    chk("a_overflow",  64'(overflow_a),  64'(m_ov));
    chk("a_busy",      64'(busy_a),      64'(m_busy));
    chk("a_wr_ready",  64'(wr_ready_a),  64'(!m_busy));
    chk_flat("a_all_data");
  endtask

  task automatic a_idle();
    clear_a = 0; addr_load_a = 0; addr_in_a = 0; wr_valid_a = 0; wr_data_a = 0;
  endtask

  initial begin
    int cnt;
    reset = 1;
    a_idle();
    rd_addr_a = 0;
    clear_b = 0; addr_load_b = 0; addr_in_b = 0; wr_valid_b = 0; wr_data_b = 0; rd_addr_b = 0;
    step();
    step();
    reset = 0;

    // reset state
    chk("rst_rd_data",  64'(rd_data_a), 0);
    chk("rst_wr_ptr",   64'(wr_ptr_a), 0);
    chk("rst_busy",     64'(busy_a), 0);
    chk("rst_ready",    64'(wr_ready_a), 1);
    chk("rst_flags",    64'({load_done_a, overflow_a}), 0);
    chk("rst_all_zero", 64'(all_a == '0), 1);
    chk("rst_b_state",  64'({wr_ready_b, wr_ptr_b, overflow_b, load_done_b}), 64'b1_00_0_0);

    // saturating instance: 5 writes into 4 words
    for (int k = 0; k < 5; k++) begin
      wr_valid_b = 1;
      wr_data_b  = 8'((k + 1) * 17);
      step();
      if (k < 3) begin
        chk("b_ready_fill", 64'(wr_ready_b), 1);
        chk("b_ptr_fill",   64'(wr_ptr_b), 64'(k + 1));
      end else begin
        chk("b_full_ready", 64'(wr_ready_b), 0);
        chk("b_ptr_hold",   64'(wr_ptr_b), 3);
        chk("b_load_done",  64'(load_done_b), 1);
      end
      if (k == 3) chk("b_no_ovf_yet", 64'(overflow_b), 0);
    end
    chk("b_overflow", 64'(overflow_b), 1);
    chk("b_words",    64'(all_b), 64'h44332211);
    wr_valid_b = 0; addr_load_b = 1; addr_in_b = 1; rd_addr_b = 2;
    step();
    addr_load_b = 0;
    chk("b_seek_ready", 64'(wr_ready_b), 1);
    chk("b_seek_ptr",   64'(wr_ptr_b), 1);
    chk("b_ovf_sticky", 64'(overflow_b), 1);
    chk("b_readback",   64'(rd_data_b), 64'h33);

    // stream 162 words 0x00..0xA1
    for (int j = 0; j < MA; j++) begin
      chk("stream_ready", 64'(wr_ready_a), 1);
      if (j == MA - 1) chk("ld_before_last", 64'(load_done_a), 0);
      wr_valid_a = 1; wr_data_a = 8'(j);
      step();
    end
    a_idle();
    chk("stream_ld",   64'(load_done_a), 1);
    chk("stream_wrap", 64'(wr_ptr_a), 0);
    for (int j = 0; j < MA; j++) chk("stream_word", 64'(all_a[j*N +: N]), 64'(j));

    // seek with simultaneous write, then bad seek
    addr_load_a = 1; addr_in_a = 10; wr_valid_a = 1; wr_data_a = 8'hAB;
    step();
    a_idle();
    chk("seek_word", 64'(all_a[10*N +: N]), 64'hAB);
    chk("seek_ptr",  64'(wr_ptr_a), 11);
    chk("seek_ovf0", 64'(overflow_a), 0);
    addr_load_a = 1; addr_in_a = 200;
    step();
    a_idle();
    chk("badseek_ovf", 64'(overflow_a), 1);
    chk("badseek_ptr", 64'(wr_ptr_a), 11);

    // readback
    addr_load_a = 1; addr_in_a = 5; wr_valid_a = 1; wr_data_a = 8'h3C;
    step();
    a_idle(); rd_addr_a = 5;
    step();
    chk("rd_word5", 64'(rd_data_a), 64'h3C);
    rd_addr_a = 170;
    step();
    chk("rd_oob", 64'(rd_data_a), 0);
    addr_load_a = 1; addr_in_a = 7; wr_valid_a = 1; wr_data_a = 8'h99; rd_addr_a = 7;
    step();
    a_idle();
    chk("rd_old_val", 64'(rd_data_a), 7);
    step();
    chk("rd_new_val", 64'(rd_data_a), 64'h99);

    // fill with 0xFF then scrub, hammering the ignored inputs meanwhile
    for (int j = 0; j < MA; j++) begin
      addr_load_a = (j == 0); addr_in_a = 0; wr_valid_a = 1; wr_data_a = 8'hFF;
      step();
    end
    a_idle();
    chk("fill_ff", 64'(all_a == '1), 1);
    clear_a = 1;
    step();
    clear_a = 0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 400) begin
      chk("scrub_ready", 64'(wr_ready_a), 0);
      wr_valid_a = 1'($urandom); wr_data_a = 8'($urandom);
      addr_load_a = 1'($urandom); addr_in_a = 8'($urandom_range(0, 255));
      clear_a = 1'($urandom); rd_addr_a = 8'($urandom_range(0, 255));
      step();
      cnt++;
    end
    a_idle();
    chk("scrub_cycles", 64'(cnt), 162);
    chk("scrub_zero",   64'(all_a == '0), 1);
    chk("scrub_ptr",    64'(wr_ptr_a), 0);
    chk("scrub_flags",  64'({load_done_a, overflow_a, busy_a}), 0);

    // reset in the middle of a scrub
    for (int j = 0; j < 20; j++) begin
      addr_load_a = (j == 0); addr_in_a = 0; wr_valid_a = 1; wr_data_a = 8'($urandom_range(1, 255));
      step();
    end
    a_idle();
    clear_a = 1;
    step();
    clear_a = 0;
    for (int j = 0; j < 50; j++) step();
    chk("midscrub_busy", 64'(busy_a), 1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy",  64'(busy_a), 0);
    chk("abort_zero",  64'(all_a == '0), 1);
    chk("abort_outs",  64'({rd_data_a, wr_ptr_a, load_done_a, overflow_a}), 0);
    chk("abort_ready", 64'(wr_ready_a), 1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      wr_valid_a  = 1'($urandom);
      wr_data_a   = 8'($urandom);
      addr_load_a = ($urandom_range(0, 7) == 0);
      addr_in_a   = 8'($urandom_range(0, 255));
      rd_addr_a   = 8'($urandom_range(0, 255));
      clear_a     = ($urandom_range(0, 299) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0;
    a_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
